// File: rtl/soc_system_clken_pkg.sv
// ---------------------------------------------------------------------------
// soc_system_clken_pkg
//
// Shared definitions for the clock-enable generator:
//   - clken_state_t : alignment FSM states (ALIGN, SETTLE, LOCKED)
//   - DEFAULT_ACC_W : default accumulator / increment width
//   - calc_inc()    : elaboration-time helper that turns a wanted strobe rate
//                     into an NCO increment, rounded to nearest
// ---------------------------------------------------------------------------
package soc_system_clken_pkg;

  localparam int DEFAULT_ACC_W = 32;

  // ALIGN loads every accumulator from its phase register, SETTLE counts off
  // the settle window, LOCKED is steady-state operation.
  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } clken_state_t;

  // inc = round(f_out * 2^acc_w / f_ref). Intended for parameter expressions,
  // e.g. calc_inc(25_000_000, 100_000_000, 32) gives 32'h4000_0000.
  // f_out must stay below 2^(64-acc_w) so the scaled value does not overflow.
  function automatic longint unsigned calc_inc(input longint unsigned f_out,
                                               input longint unsigned f_ref,
                                               input int unsigned     acc_w);
    longint unsigned scaled;
    scaled = f_out << acc_w;
    return (scaled + (f_ref >> 1)) / f_ref;
  endfunction

endpackage

// File: rtl/soc_system_clken_nco_ch.sv
// ---------------------------------------------------------------------------
// soc_system_clken_nco_ch
//
// One strobe channel: increment, start-phase and accumulator registers plus
// the carry-out flop that forms the strobe.
//
// Ports:
//   refclk     in   reference clock, rising edge
//   rst        in   asynchronous active-high reset
//   load       in   capture load_inc / load_phase into the channel registers
//   load_inc   in   new increment
//   load_phase in   new accumulator start value
//   align      in   restart the accumulator from the phase register
//   accumulate in   advance the accumulator by one increment
//   clken      out  registered carry of the accumulator (single-cycle strobe)
// ---------------------------------------------------------------------------
module soc_system_clken_nco_ch
  import soc_system_clken_pkg::*;
#(
  parameter int               ACC_W     = DEFAULT_ACC_W,
  parameter logic [ACC_W-1:0] INC_RESET = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  input  logic             align,
  input  logic             accumulate,
  output logic             clken
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] phase_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder: its MSB is the wrap-around carry that
  // becomes the strobe, the low bits are the accumulator modulo 2^ACC_W.
  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // Programmable rate and start phase. Reset brings the channel back to its
  // build-time rate with zero phase.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      inc_q   <= INC_RESET;
      phase_q <= '0;
    end else if (load) begin
      inc_q   <= load_inc;
      phase_q <= load_phase;
    end
  end

  // Accumulator and strobe. Alignment restarts the accumulator and suppresses
  // the strobe for that cycle so every channel restarts from a known point.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      clken <= 1'b0;
    end else if (align) begin
      acc_q <= phase_q;
      clken <= 1'b0;
    end else if (accumulate) begin
      acc_q <= sum[ACC_W-1:0];
      clken <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/soc_system_clken_gen.sv
// ---------------------------------------------------------------------------
// soc_system_clken_gen
//
// Runtime-reprogrammable fractional clock-enable generator. Each of NUM_CH
// channels is a phase accumulator clocked by refclk; its carry is a strobe of
// rate f_refclk * inc / 2^ACC_W. Any accepted reconfiguration re-aligns all
// channels together, and 'locked' behaves like a PLL lock: low during
// re-alignment, high after LOCK_CYCLES settle cycles.
//
// Ports:
//   refclk     in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration can be accepted (low only while aligning)
//   cfg_ch     in   target channel; values >= NUM_CH are accepted and ignored
//   cfg_inc    in   new increment for the target channel
//   cfg_phase  in   new accumulator start value for the target channel
//   clken      out  per-channel single-cycle strobes
//   locked     out  strobes are aligned and settled
// ---------------------------------------------------------------------------
module soc_system_clken_gen
  import soc_system_clken_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      ACC_W       = DEFAULT_ACC_W,
  parameter int                      LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = {32'h4000_0000, 32'h8000_0000},
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clken,
  output logic              locked
);

  localparam int              LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  clken_state_t      state;
  clken_state_t      next_state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_cnt_next;
  logic              xfer;
  logic              ch_in_range;
  logic              cfg_hit;
  logic              align;
  logic              accumulate;
  logic [NUM_CH-1:0] load;

  // A request can only be taken while the channels are running; the single
  // ALIGN cycle is the only time the interface stalls.
  assign cfg_ready   = (state != ALIGN);
  assign xfer        = cfg_valid && cfg_ready;

  // Out-of-range channels complete the handshake but must not disturb
  // anything, including the lock state.
  assign ch_in_range = (32'(cfg_ch) < NUM_CH);
  assign cfg_hit     = xfer && ch_in_range;

  assign align       = (state == ALIGN);
  assign accumulate  = (state != ALIGN);

  // Next-state and lock-counter logic. A configuration hit takes priority
  // over everything else, including the SETTLE->LOCKED step on the last
  // settle cycle, so a late write always restarts the settle window.
  always_comb begin
    next_state    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      ALIGN: begin
        next_state    = SETTLE;
        lock_cnt_next = '0;
      end
      SETTLE: begin
        lock_cnt_next = lock_cnt + 1'b1;
        if (lock_cnt == LOCK_LAST) begin
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        next_state = LOCKED;
      end
      default: begin
        next_state    = ALIGN;
        lock_cnt_next = '0;
      end
    endcase
    if (cfg_hit) begin
      next_state    = ALIGN;
      lock_cnt_next = '0;
    end
  end

  // FSM state, settle counter and the registered lock flag. 'locked' is fed
  // from next_state so it is a clean flop output that always equals
  // (state == LOCKED) and drops on the same edge a reconfiguration lands.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ALIGN;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= next_state;
      lock_cnt <= lock_cnt_next;
      locked   <= (next_state == LOCKED);
    end
  end

  // One accumulator per channel. The channel select is decoded here so each
  // channel only sees its own load strobe; alignment is broadcast so all
  // channels restart on the same edge.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = cfg_hit && (cfg_ch == CH_W'(i));

    soc_system_clken_nco_ch #(
      .ACC_W     (ACC_W),
      .INC_RESET (INC_INIT[i*ACC_W +: ACC_W])
    ) u_nco (
      .refclk     (refclk),
      .rst        (rst),
      .load       (load[i]),
      .load_inc   (cfg_inc),
      .load_phase (cfg_phase),
      .align      (align),
      .accumulate (accumulate),
      .clken      (clken[i])
    );
  end

endmodule
